// File: rtl/alu_sequencer_if.sv
// Bus bundle between the ALU sequencer and its environment: the instruction
// handshake, the result handshake, the ALU operand/result wires and the
// debug register read port.
interface alu_sequencer_if #(
    parameter int WIDTH = 16,
    parameter int AW    = 2
);
    logic             instr_valid;
    logic             instr_ready;
    logic             instr_ld;
    logic [3:0]       instr_op;
    logic [AW-1:0]    instr_rd;
    logic [AW-1:0]    instr_ra;
    logic [AW-1:0]    instr_rb;
    logic [WIDTH-1:0] instr_imm;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [3:0]       alu_s;
    logic [WIDTH-1:0] alu_out;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [AW-1:0]    res_rd;
    logic             res_zero;
    logic             res_neg;

    logic [AW-1:0]    dbg_addr;
    logic [WIDTH-1:0] dbg_data;

    // The sequencer itself.
    modport slave (
        input  instr_valid, instr_ld, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        input  alu_out, res_ready, dbg_addr,
        output instr_ready, alu_a, alu_b, alu_s,
        output res_valid, res_data, res_rd, res_zero, res_neg, dbg_data
    );

    // Instruction producer, result consumer and ALU side.
    modport master (
        output instr_valid, instr_ld, instr_op, instr_rd, instr_ra, instr_rb, instr_imm,
        output alu_out, res_ready, dbg_addr,
        input  instr_ready, alu_a, alu_b, alu_s,
        input  res_valid, res_data, res_rd, res_zero, res_neg, dbg_data
    );
endinterface

// File: rtl/alu_sequencer.sv
// Register file and sequencing stage in front of the 16-bit combinational ALU.
// One instruction is in flight at a time: IDLE accepts it, EXEC lets the ALU
// settle on registered operands, RESP presents the result until consumed.
module alu_sequencer #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int AW    = 2
) (
    input logic           clk,
    input logic           rst_n,
    alu_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic [3:0]       alu_s_q;
    logic [WIDTH-1:0] res_data_q;
    logic [AW-1:0]    res_rd_q;
    logic             accept;

    assign accept = bus.instr_valid && (state == IDLE);

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: loads skip EXEC, ALU ops spend one cycle there.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.instr_valid) begin
                    state_next = bus.instr_ld ? RESP : EXEC;
                end
            end
            EXEC: state_next = RESP;
            RESP: begin
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: operand capture on accept, writeback on load accept or at end of EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_s_q    <= '0;
            res_data_q <= '0;
            res_rd_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        res_rd_q <= bus.instr_rd;
                        if (bus.instr_ld) begin
                            regs[bus.instr_rd] <= bus.instr_imm;
                            res_data_q         <= bus.instr_imm;
                        end else begin
                            alu_a_q <= regs[bus.instr_ra];
                            alu_b_q <= regs[bus.instr_rb];
                            alu_s_q <= bus.instr_op;
                        end
                    end
                end
                EXEC: begin
                    regs[res_rd_q] <= bus.alu_out;
                    res_data_q     <= bus.alu_out;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.instr_ready = (state == IDLE);
    assign bus.res_valid   = (state == RESP);
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_s       = alu_s_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_rd      = res_rd_q;
    assign bus.res_zero    = (res_data_q == '0);
    assign bus.res_neg     = res_data_q[WIDTH-1];
    assign bus.dbg_data    = regs[bus.dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural ALU drives alu_out,
// and a plain register-array model predicts every result, latency and flag.
module tb_alu_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] model_regs [4];

    alu_sequencer_if #(.WIDTH(16), .AW(2)) bus ();

    alu_sequencer #(.WIDTH(16), .NREG(4), .AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ALU select-code table, modulo 2^16.
    function automatic logic [15:0] alu_fn(input logic [3:0] s, input logic [15:0] a,
                                           input logic [15:0] b);
        logic [15:0] r;
        case (s)
            4'd0:    r = a + b;
            4'd1:    r = a - b;
            4'd2:    r = b - a;
            4'd3:    r = 16'h0000;
            4'd4:    r = 16'h0001;
            4'd5:    r = 16'hFFFF;
            4'd6:    r = 16'h0000 - a;
            4'd7:    r = 16'h0000 - b;
            4'd8:    r = ~a;
            4'd9:    r = ~b;
            4'd10:   r = a + 16'd1;
            4'd11:   r = b + 16'd1;
            4'd12:   r = a - 16'd1;
            4'd13:   r = b - 16'd1;
            4'd14:   r = a & b;
            default: r = a | b;
        endcase
        return r;
    endfunction

    assign bus.alu_out = alu_fn(bus.alu_s, bus.alu_a, bus.alu_b);

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Issue one instruction, check latency, result, flags and writeback,
    // optionally holding off res_ready while a second instruction waits.
    task automatic applyStimulus(input bit ld, input logic [3:0] op, input logic [1:0] rd,
                                 input logic [1:0] ra, input logic [1:0] rb,
                                 input logic [15:0] imm, input int hold);
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] expv;
        int guard;
        a    = model_regs[ra];
        b    = model_regs[rb];
        expv = ld ? imm : alu_fn(op, a, b);

        bus.instr_ld    = ld;
        bus.instr_op    = op;
        bus.instr_rd    = rd;
        bus.instr_ra    = ra;
        bus.instr_rb    = rb;
        bus.instr_imm   = imm;
        bus.instr_valid = 1'b1;
        guard = 0;
        while (!bus.instr_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 20) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            bus.instr_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;

        if (!ld) begin
            checkOutput("exec_res_valid", 32'(bus.res_valid), 32'd0);
            checkOutput("exec_instr_ready", 32'(bus.instr_ready), 32'd0);
            checkOutput("alu_a", 32'(bus.alu_a), 32'(a));
            checkOutput("alu_b", 32'(bus.alu_b), 32'(b));
            checkOutput("alu_s", 32'(bus.alu_s), 32'(op));
            @(posedge clk); #1;
        end

        model_regs[rd] = expv;
        checkOutput("res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("res_data", 32'(bus.res_data), 32'(expv));
        checkOutput("res_rd", 32'(bus.res_rd), 32'(rd));
        checkOutput("res_zero", 32'(bus.res_zero), 32'(expv == 16'h0000));
        checkOutput("res_neg", 32'(bus.res_neg), 32'(expv[15]));
        bus.dbg_addr = rd;
        #1;
        checkOutput("dbg_data", 32'(bus.dbg_data), 32'(expv));

        for (int i = 0; i < hold; i++) begin
            bus.instr_ld    = 1'b1;
            bus.instr_rd    = rd;
            bus.instr_imm   = 16'hDEAD;
            bus.instr_valid = 1'b1;
            @(posedge clk); #1;
            checkOutput("hold_res_valid", 32'(bus.res_valid), 32'd1);
            checkOutput("hold_res_data", 32'(bus.res_data), 32'(expv));
            checkOutput("hold_instr_ready", 32'(bus.instr_ready), 32'd0);
        end

        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready   = 1'b0;
        bus.instr_valid = 1'b0;
        checkOutput("idle_instr_ready", 32'(bus.instr_ready), 32'd1);
        checkOutput("idle_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("idle_no_overwrite", 32'(bus.dbg_data), 32'(expv));
    endtask

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence: reset, directed test-plan cases, random mix, mid-op reset.
    initial begin
        bus.instr_valid = 1'b0;
        bus.instr_ld    = 1'b0;
        bus.instr_op    = 4'd0;
        bus.instr_rd    = 2'd0;
        bus.instr_ra    = 2'd0;
        bus.instr_rb    = 2'd0;
        bus.instr_imm   = 16'h0000;
        bus.res_ready   = 1'b0;
        bus.dbg_addr    = 2'd0;
        for (int i = 0; i < 4; i++) model_regs[i] = 16'h0000;

        #2 rst_n = 1'b0;
        #10;
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        checkOutput("rst_alu_a", 32'(bus.alu_a), 32'd0);
        checkOutput("rst_alu_b", 32'(bus.alu_b), 32'd0);
        checkOutput("rst_alu_s", 32'(bus.alu_s), 32'd0);
        checkOutput("rst_res_data", 32'(bus.res_data), 32'd0);
        checkOutput("rst_res_rd", 32'(bus.res_rd), 32'd0);
        for (int i = 0; i < 4; i++) begin
            bus.dbg_addr = 2'(i);
            #1;
            checkOutput("rst_reg", 32'(bus.dbg_data), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 16'h0040, 0);
        applyStimulus(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 16'h0020, 0);
        applyStimulus(1'b0, 4'd0, 2'd2, 2'd0, 2'd1, 16'h0000, 0);
        checkOutput("tp_add", 32'(bus.res_data), 32'h0060);
        applyStimulus(1'b0, 4'd2, 2'd3, 2'd0, 2'd1, 16'h0000, 0);
        checkOutput("tp_bsuba", 32'(bus.res_data), 32'hFFE0);
        checkOutput("tp_bsuba_neg", 32'(bus.res_neg), 32'd1);
        applyStimulus(1'b0, 4'd1, 2'd3, 2'd1, 2'd1, 16'h0000, 0);
        checkOutput("tp_zero_flag", 32'(bus.res_zero), 32'd1);

        for (int s = 0; s < 16; s++) begin
            applyStimulus(1'b0, 4'(s), 2'd3, 2'd0, 2'd1, 16'h0000, 0);
            if (s == 12) checkOutput("tp_op12", 32'(bus.res_data), 32'h003F);
            if (s == 8)  checkOutput("tp_op8", 32'(bus.res_data), 32'hFFBF);
            if (s == 15) checkOutput("tp_op15", 32'(bus.res_data), 32'h0060);
        end

        applyStimulus(1'b0, 4'd0, 2'd2, 2'd0, 2'd1, 16'h0000, 3);
        applyStimulus(1'b1, 4'd0, 2'd2, 2'd0, 2'd0, 16'h1234, 0);

        applyStimulus(1'b1, 4'd0, 2'd0, 2'd0, 2'd0, 16'h0005, 0);
        applyStimulus(1'b0, 4'd10, 2'd0, 2'd0, 2'd0, 16'h0000, 0);
        checkOutput("tp_alias1", 32'(bus.res_data), 32'd6);
        applyStimulus(1'b0, 4'd10, 2'd0, 2'd0, 2'd0, 16'h0000, 0);
        checkOutput("tp_alias2", 32'(bus.res_data), 32'd7);

        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)),
                          2'($urandom_range(3, 0)), 2'($urandom_range(3, 0)),
                          2'($urandom_range(3, 0)), 16'($urandom_range(65535, 0)),
                          int'($urandom_range(2, 0)));
        end

        applyStimulus(1'b1, 4'd0, 2'd2, 2'd0, 2'd0, 16'h0009, 0);
        bus.instr_ld    = 1'b0;
        bus.instr_op    = 4'd0;
        bus.instr_rd    = 2'd2;
        bus.instr_ra    = 2'd0;
        bus.instr_rb    = 2'd1;
        bus.instr_valid = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        checkOutput("midrst_in_exec", 32'(bus.res_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) model_regs[i] = 16'h0000;
        checkOutput("midrst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("midrst_instr_ready", 32'(bus.instr_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.dbg_addr = 2'(i);
            #1;
            checkOutput("midrst_reg", 32'(bus.dbg_data), 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_rst_ready", 32'(bus.instr_ready), 32'd1);
        checkOutput("post_rst_valid", 32'(bus.res_valid), 32'd0);
        bus.dbg_addr = 2'd2;
        #1;
        checkOutput("post_rst_r2", 32'(bus.dbg_data), 32'd0);
        applyStimulus(1'b1, 4'd0, 2'd1, 2'd0, 2'd0, 16'h8000, 0);
        applyStimulus(1'b0, 4'd15, 2'd2, 2'd1, 2'd0, 16'h0000, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
